// File: rtl/axis32to8.sv
// 32-bit keep/last word stream to byte stream unpacker.
// Emits kept lanes in configurable order, one byte per cycle, with no bubble between words.
module axis32to8 #(
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] m_data,
   input  logic [3:0]  m_keep,
   input  logic        m_last,
   input  logic        m_valid,
   output logic        m_ready,
   output logic [7:0]  s_data,
   output logic        s_last,
   output logic        s_valid,
   input  logic        s_ready,
   output logic        drop_seen
);

   logic [31:0] word;
   logic [3:0]  pend;
   logic        hlast;

   logic [1:0]  cur_idx;
   logic [3:0]  cur_bit;
   logic        busy;
   logic        fin;
   logic        load;
   logic        take;

   // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
   always_comb begin
      cur_idx = 2'd0;
      if (LSB_FIRST) begin
         for (int i = 3; i >= 0; i--)
            if (pend[i]) cur_idx = 2'(i);
      end else begin
         for (int i = 0; i < 4; i++)
            if (pend[i]) cur_idx = 2'(i);
      end
   end

   assign cur_bit = 4'b0001 << cur_idx;
   assign busy    = |pend;
   assign fin     = (pend == cur_bit);

   assign s_valid = busy;
   assign s_data  = word[{cur_idx, 3'b000} +: 8];
   assign s_last  = busy & fin & hlast;

   // Ready looks through to s_ready so the next word loads in the same cycle the final byte leaves.
   assign m_ready = ~rst & (~busy | (fin & s_ready));

   assign take = s_valid & s_ready;
   assign load = m_valid & m_ready;

   // NOTE: sequential state uses non-blocking assignments; the later load assignment to pend
   // overrides the lane clear, which gives the load priority within a cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         word      <= 32'h0;
         pend      <= 4'h0;
         hlast     <= 1'b0;
         drop_seen <= 1'b0;
      end else begin
         if (take)
            pend <= pend & ~cur_bit;
         if (load) begin
            word  <= m_data;
            pend  <= m_keep;
            hlast <= m_last & (|m_keep);
            if (m_keep == 4'h0)
               drop_seen <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_axis32to8.sv
// Bench for axis32to8: both emit orders side by side, scoreboard of expected bytes,
// table of hand-computed words plus timing, gapless, stall and mid-word reset sequences.
module tb_axis32to8;

   typedef struct packed {
      logic [7:0] data;
      logic       last;
   } exp_t;

   typedef struct {
      logic [31:0] data;
      logic [3:0]  keep;
      logic        last;
      int          n;
      logic [31:0] exp_lsb;
      logic [31:0] exp_msb;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] m_data;
   logic [3:0]  m_keep;
   logic        m_last;
   logic        m_valid;
   logic        s_ready;
   logic        m_ready   [2];
   logic [7:0]  s_data    [2];
   logic        s_last    [2];
   logic        s_valid   [2];
   logic        drop_seen [2];

   int   checks = 0;
   int   errors = 0;
   exp_t q_lsb[$];
   exp_t q_msb[$];
   logic exp_drop;
   logic stim_done;
   vec_t vecs [5];

   always #5 clk = ~clk;

   axis32to8 #(.LSB_FIRST(1'b1)) u_lsb (
      .clk(clk), .rst(rst), .m_data(m_data), .m_keep(m_keep), .m_last(m_last),
      .m_valid(m_valid), .m_ready(m_ready[0]), .s_data(s_data[0]), .s_last(s_last[0]),
      .s_valid(s_valid[0]), .s_ready(s_ready), .drop_seen(drop_seen[0])
   );

   axis32to8 #(.LSB_FIRST(1'b0)) u_msb (
      .clk(clk), .rst(rst), .m_data(m_data), .m_keep(m_keep), .m_last(m_last),
      .m_valid(m_valid), .m_ready(m_ready[1]), .s_data(s_data[1]), .s_last(s_last[1]),
      .s_valid(s_valid[1]), .s_ready(s_ready), .drop_seen(drop_seen[1])
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: kept lanes packed in emit order, first emitted byte in exp[7:0].
   function automatic void model(input logic [31:0] d, input logic [3:0] kp, input bit lsb,
                                 output int n, output logic [31:0] e);
      int lane;
      n = 0;
      e = 32'h0;
      for (int j = 0; j < 4; j++) begin
         lane = lsb ? j : 3 - j;
         if (kp[lane]) begin
            e[8*n +: 8] = d[8*lane +: 8];
            n++;
         end
      end
   endfunction

   task automatic send_word(input logic [31:0] d, input logic [3:0] kp, input logic l,
                            input int n, input logic [31:0] el, input logic [31:0] em);
      bit ok = 1'b0;
      m_data  = d;
      m_keep  = kp;
      m_last  = l;
      m_valid = 1'b1;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         if (m_ready[0] === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         check("accept_timeout", 32'd0, 32'd1);
         m_valid = 1'b0;
         return;
      end
      check("m_ready_msb_agrees", 32'(m_ready[1]), 32'd1);
      for (int i = 0; i < n; i++) begin
         q_lsb.push_back('{data: el[8*i +: 8], last: l && (i == n - 1)});
         q_msb.push_back('{data: em[8*i +: 8], last: l && (i == n - 1)});
      end
      @(posedge clk);
      #1;
      m_valid = 1'b0;
      if (kp == 4'h0) exp_drop = 1'b1;
   endtask

   task automatic send_model(input logic [31:0] d, input logic [3:0] kp, input logic l);
      int          n0, n1;
      logic [31:0] e0, e1;
      model(d, kp, 1'b1, n0, e0);
      model(d, kp, 1'b0, n1, e1);
      send_word(d, kp, l, n0, e0, e1);
   endtask

   task automatic drain();
      for (int c = 0; c < 200; c++) begin
         if (q_lsb.size() == 0 && q_msb.size() == 0) break;
         @(negedge clk);
      end
      check("drain", 32'(q_lsb.size() + q_msb.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   // Monitor: pops expected bytes on each transfer and checks hold-during-stall behaviour.
   initial begin
      bit         prev_stall [2];
      logic [7:0] prev_data  [2];
      logic       prev_last  [2];
      exp_t       e;
      prev_stall = '{1'b0, 1'b0};
      forever begin
         @(negedge clk);
         if (rst !== 1'b0) begin
            prev_stall = '{1'b0, 1'b0};
         end else begin
            for (int k = 0; k < 2; k++) begin
               if (prev_stall[k]) begin
                  check($sformatf("stall_valid%0d", k), 32'(s_valid[k]), 32'd1);
                  check($sformatf("stall_data%0d", k), 32'(s_data[k]), 32'(prev_data[k]));
                  check($sformatf("stall_last%0d", k), 32'(s_last[k]), 32'(prev_last[k]));
               end
               if (s_valid[k] === 1'b1 && s_ready === 1'b1) begin
                  if ((k == 0 ? q_lsb.size() : q_msb.size()) == 0) begin
                     check($sformatf("unexpected_byte%0d", k), 32'(s_data[k]), 32'hxxxx_xxxx);
                  end else begin
                     e = (k == 0) ? q_lsb.pop_front() : q_msb.pop_front();
                     check($sformatf("byte%0d", k), 32'(s_data[k]), 32'(e.data));
                     check($sformatf("last%0d", k), 32'(s_last[k]), 32'(e.last));
                  end
               end
               check($sformatf("drop_seen%0d", k), 32'(drop_seen[k]), 32'(exp_drop));
               prev_stall[k] = (s_valid[k] === 1'b1) && (s_ready === 1'b0);
               prev_data[k]  = s_data[k];
               prev_last[k]  = s_last[k];
            end
         end
      end
   end

   initial begin
      int cnt;
      rst       = 1'b1;
      m_valid   = 1'b0;
      m_data    = 32'h0;
      m_keep    = 4'h0;
      m_last    = 1'b0;
      s_ready   = 1'b1;
      exp_drop  = 1'b0;
      stim_done = 1'b0;

      vecs[0] = '{32'hDDCCBBAA, 4'hF, 1'b1, 4, 32'hDDCCBBAA, 32'hAABBCCDD};
      vecs[1] = '{32'h44332211, 4'hA, 1'b1, 2, 32'h00004422, 32'h00002244};
      vecs[2] = '{32'h44332211, 4'h1, 1'b1, 1, 32'h00000011, 32'h00000011};
      vecs[3] = '{32'hFFFFFFFF, 4'h0, 1'b1, 0, 32'h00000000, 32'h00000000};
      vecs[4] = '{32'h0D0C0B0A, 4'hF, 1'b0, 4, 32'h0D0C0B0A, 32'h0A0B0C0D};

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         check($sformatf("rst_m_ready%0d", k), 32'(m_ready[k]), 32'd0);
         check($sformatf("rst_s_valid%0d", k), 32'(s_valid[k]), 32'd0);
         check($sformatf("rst_s_data%0d", k), 32'(s_data[k]), 32'h00);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         check($sformatf("post_rst_m_ready%0d", k), 32'(m_ready[k]), 32'd1);
         check($sformatf("post_rst_s_valid%0d", k), 32'(s_valid[k]), 32'd0);
         check($sformatf("post_rst_s_last%0d", k), 32'(s_last[k]), 32'd0);
         check($sformatf("post_rst_s_data%0d", k), 32'(s_data[k]), 32'h00);
      end
      @(posedge clk);
      #1;

      // Single word: latency and m_ready only in the fin cycle
      send_model(32'hDDCCBBAA, 4'hF, 1'b1);
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            check($sformatf("cyc%0d_s_valid%0d", i, k), 32'(s_valid[k]), 32'd1);
            check($sformatf("cyc%0d_m_ready%0d", i, k), 32'(m_ready[k]), 32'(i == 4));
         end
      end
      @(negedge clk);
      check("cyc5_s_valid", 32'(s_valid[0]), 32'd0);
      @(posedge clk);
      #1;

      // Table: sparse keep, single lane, zero keep, then no-last word
      for (int v = 0; v < 5; v++)
         send_word(vecs[v].data, vecs[v].keep, vecs[v].last, vecs[v].n,
                   vecs[v].exp_lsb, vecs[v].exp_msb);
      drain();

      // Three back-to-back words: 12 consecutive valid cycles
      fork
         begin
            send_model(32'hDDCCBBAA, 4'hF, 1'b0);
            send_model(32'h11223344, 4'hF, 1'b0);
            send_model(32'h55667788, 4'hF, 1'b1);
         end
         begin
            cnt = 0;
            for (int c = 0; c < 20 && s_valid[0] !== 1'b1; c++) @(negedge clk);
            while (s_valid[0] === 1'b1 && cnt < 20) begin
               cnt++;
               @(negedge clk);
            end
            check("gapless_run", 32'(cnt), 32'd12);
         end
      join
      drain();

      // Random backpressure over 16 random words
      fork
         begin
            for (int w = 0; w < 16; w++)
               send_model($urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            stim_done = 1'b1;
         end
         begin
            while (!stim_done) begin
               s_ready = 1'($urandom_range(0, 1));
               @(posedge clk);
               #1;
            end
         end
      join
      s_ready = 1'b1;
      drain();

      // Reset during the second byte of a word
      send_model(32'h87654321, 4'hF, 1'b1);
      @(negedge clk);
      @(posedge clk);
      #1;
      rst     = 1'b1;
      s_ready = 1'b0;
      q_lsb.delete();
      q_msb.delete();
      exp_drop = 1'b0;
      @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         check($sformatf("midrst_s_valid%0d", k), 32'(s_valid[k]), 32'd0);
         check($sformatf("midrst_s_last%0d", k), 32'(s_last[k]), 32'd0);
         check($sformatf("midrst_m_ready%0d", k), 32'(m_ready[k]), 32'd0);
      end
      @(posedge clk);
      #1;
      rst     = 1'b0;
      s_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         check("after_rst_idle", 32'(s_valid[0] | s_valid[1]), 32'd0);
      end
      @(posedge clk);
      #1;
      send_model(32'hCAFEF00D, 4'h5, 1'b1);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1);
   end

endmodule

// File: doc/axis32to8.md
# axis32to8

Downstream counterpart to the 8→32 stream packer: accepts 32-bit AXI-Stream-style words with per-byte keep and a last flag, and emits them as a single-byte stream. It sits between the word-wide datapath and byte-wide consumers such as UART, SPI, and byte FIFOs. It sustains one byte per cycle across word boundaries, skips lanes whose keep bit is clear, and moves `last` onto the final emitted byte.

## Interface
- `LSB_FIRST`, default 1: 1 = emit lane 0 (`m_data[7:0]`) first, ascending; 0 = emit lane 3 (`m_data[31:24]`) first, descending.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `m_data`  in  32  input word.
- `m_keep`  in  4  byte-lane enables; bit i qualifies `m_data[8i+7:8i]`.
- `m_last`  in  1  word ends a packet.
- `m_valid`  in  1  input word valid.
- `m_ready`  out  1  block accepts the input word this cycle.
- `s_data`  out  8  output byte.
- `s_last`  out  1  byte is the last byte of a packet.
- `s_valid`  out  1  output byte valid.
- `s_ready`  in  1  downstream accepts the output byte.
- `drop_seen`  out  1  sticky flag: a word with `m_keep == 0` was consumed.

## Operation
- A holding register stores: `word[31:0]`, `pend[3:0]` (lanes not yet emitted), and `hlast`.
- `busy = |pend`.
- `s_valid = busy`.
- Current lane: the first set bit of `pend` in emit order. With `LSB_FIRST=1` this is the lowest set bit; otherwise the highest set bit.
- `s_data` is the current lane's byte.
- `fin` = current lane is the only set bit in `pend`.
- `s_last = busy & fin & hlast`.
- On `s_valid & s_ready`, clear the current lane's bit in `pend`.
- `m_ready = ~rst & (~busy | (fin & s_ready))`. This is a combinational path from `s_ready` to `m_ready`, and it is required for gapless throughput.
- On `m_valid & m_ready`, load `word <= m_data`, `pend <= m_keep`, `hlast <= m_last`.
- The load has priority over the lane-clear in the same cycle.
- Sparse keep (e.g. `4'b1010`): only the set lanes are emitted, in emit order. Clear lanes are never presented.
- Zero-keep word (`m_keep == 0`):
  - It is accepted and produces no output byte.
  - Its `m_last` is discarded.
  - It sets `drop_seen`.
  - `pend` stays 0, so the block stays ready the next cycle.
- `drop_seen` clears only on `rst`.
- Output stability: while `s_valid & ~s_ready`, `s_data`, `s_last`, and `s_valid` hold constant.
- No state machine beyond `pend`:
  - IDLE is `pend == 0`.
  - EMIT is `pend != 0`.
  - EMIT→IDLE when the `fin` byte transfers and no new word is loaded.
  - EMIT→EMIT (reload) when the `fin` byte transfers together with an input accept.

## Timing
- Reset: `pend <= 0`, `word <= 0`, `hlast <= 0`, `drop_seen <= 0`.
- Outputs while `rst` is high and on the first cycle after: `s_valid=0`, `s_data=8'h00`, `s_last=0`, `m_ready=0` during `rst`, then `m_ready=1` in the first cycle after `rst` deasserts.
- Latency: a word accepted at edge N presents its first byte as `s_valid` in cycle N+1.
- Throughput: with `s_ready` held high, a word with k set keep bits occupies k cycles. Back-to-back words emit with no bubble.
- `m_ready` is high exactly in the `fin` cycle of each word.
- Zero-keep words each cost one accept cycle and insert no output bubble once the holding register is empty.
- Backpressure: `s_ready=0` in a `fin` cycle forces `m_ready=0`. No input is accepted until that byte transfers.
- Reset mid-word: any pending bytes are discarded. No partial byte or `s_last` appears after reset.

## Test plan
- Single word `32'hDDCCBBAA`, keep `4'hF`, last=1, `s_ready=1`, `LSB_FIRST=1`:
  - output is AA, BB, CC, DD on cycles 1–4;
  - `s_last` is set only with DD;
  - `m_ready` is low on cycles 1–3 and high on cycle 4.
- Same word with `LSB_FIRST=0`: output is DD, CC, BB, AA, with `s_last` on AA.
- Three back-to-back full words with `s_ready=1`:
  - 12 consecutive `s_valid` cycles with no gap;
  - `s_last` only on byte 12 when last is set only on word 3.
- Sparse keep `4'b1010` on `32'h44332211`, last=1: output is 22 then 44 (with `s_last`). Then keep `4'b0001`: single byte 11.
- Zero-keep word with last=1, followed by keep `4'hF` `32'h0D0C0B0A` last=0:
  - zero-keep word yields no byte;
  - `drop_seen` goes to 1;
  - output is 0A..0D with no `s_last`.
- Random `s_ready` stall pattern (e.g. 1,0,0,1,0,1...) over 16 words:
  - `s_data`/`s_last` stay stable during stalls;
  - the byte sequence matches the reference model;
  - assert `rst` during byte 2 of a word → `s_valid=0` next cycle and the remaining bytes are never emitted.
